// File: rtl/gcn_transform_scheduler.sv
// gcn_transform_scheduler: sequences feature x weight combination, one output element at a time.
// Ports: clk/reset(async low), start/abort/out_ready in; busy, read/mac/write strobes, indices, done out.
module gcn_transform_scheduler #(
  parameter int FEATURE_ROWS = 6,
  parameter int FEATURE_COLS = 96,
  parameter int WEIGHT_COLS  = 3,
  parameter int ROW_WIDTH = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1,
  parameter int K_WIDTH   = (FEATURE_COLS > 1) ? $clog2(FEATURE_COLS) : 1,
  parameter int COL_WIDTH = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 read_en,
  output logic [ROW_WIDTH-1:0] feature_row,
  output logic [K_WIDTH-1:0]   k_index,
  output logic [COL_WIDTH-1:0] weight_col,
  output logic                 mac_clear,
  output logic                 mac_en,
  output logic                 write_en,
  output logic [ROW_WIDTH-1:0] write_row,
  output logic [COL_WIDTH-1:0] write_col,
  output logic                 done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] READ  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam logic [ROW_WIDTH-1:0] R_LAST =
    ROW_WIDTH'(FEATURE_ROWS - 1);
  localparam logic [K_WIDTH-1:0] K_LAST =
    K_WIDTH'(FEATURE_COLS - 1);
  localparam logic [COL_WIDTH-1:0] C_LAST =
    COL_WIDTH'(WEIGHT_COLS - 1);

  logic [2:0] state;
  logic       last_row;
  logic       last_col;

  assign last_row = (feature_row == R_LAST);
  assign last_col = (weight_col == C_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      read_en     <= 1'b0;
      feature_row <= '0;
      k_index     <= '0;
      weight_col  <= '0;
      mac_clear   <= 1'b0;
      mac_en      <= 1'b0;
      write_en    <= 1'b0;
      write_row   <= '0;
      write_col   <= '0;
      done        <= 1'b0;
    end else if (abort) begin
      // Also kills a mac_en still in flight
      // from the final read.
      state       <= IDLE;
      busy        <= 1'b0;
      read_en     <= 1'b0;
      feature_row <= '0;
      k_index     <= '0;
      weight_col  <= '0;
      mac_clear   <= 1'b0;
      mac_en      <= 1'b0;
      write_en    <= 1'b0;
      write_row   <= '0;
      write_col   <= '0;
      done        <= 1'b0;
    end else begin
      // Operands arrive one cycle after the read.
      mac_en <= read_en;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= CLEAR;
            busy      <= 1'b1;
            mac_clear <= 1'b1;
          end
        end
        CLEAR: begin
          state     <= READ;
          mac_clear <= 1'b0;
          read_en   <= 1'b1;
          k_index   <= '0;
        end
        READ: begin
          if (k_index == K_LAST) begin
            state   <= DRAIN;
            read_en <= 1'b0;
          end else begin
            k_index <= k_index + K_WIDTH'(1);
          end
        end
        DRAIN: begin
          state     <= WRITE;
          write_en  <= 1'b1;
          write_row <= feature_row;
          write_col <= weight_col;
        end
        WRITE: begin
          if (out_ready) begin
            write_en <= 1'b0;
            if (last_col) begin
              weight_col  <= '0;
              feature_row <= feature_row + ROW_WIDTH'(1);
            end else begin
              weight_col <= weight_col + COL_WIDTH'(1);
            end
            if (last_row && last_col) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= CLEAR;
              mac_clear <= 1'b1;
            end
          end
        end
        DONE: begin
          state       <= IDLE;
          done        <= 1'b0;
          busy        <= 1'b0;
          feature_row <= '0;
          weight_col  <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcn_transform_scheduler.sv
// tb_gcn_transform_scheduler: random and directed passes vs a position-based model.
// Ports: none; drives a 2/4/3 instance and a 1/1/1 instance from one clock.
module tb_gcn_transform_scheduler;

  localparam int FR = 2;
  localparam int FC = 4;
  localparam int WC = 3;
  localparam int L  = FC + 3;
  localparam int E  = FR * WC;
  localparam int N  = E * L + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       out_ready = 1'b1;
  logic       busy, read_en, mac_clear, mac_en;
  logic       write_en, done;
  logic [0:0] feature_row, write_row;
  logic [1:0] k_index, weight_col, write_col;

  logic       s_start = 1'b0;
  logic       s_abort = 1'b0;
  logic       s_ready = 1'b1;
  logic       s_busy, s_read, s_clear, s_mac;
  logic       s_write, s_done;
  logic [0:0] s_row, s_k, s_col, s_wrow, s_wcol;

  always #5 clk = ~clk;

  gcn_transform_scheduler #(
    .FEATURE_ROWS(FR),
    .FEATURE_COLS(FC),
    .WEIGHT_COLS(WC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .out_ready(out_ready),
    .busy(busy),
    .read_en(read_en),
    .feature_row(feature_row),
    .k_index(k_index),
    .weight_col(weight_col),
    .mac_clear(mac_clear),
    .mac_en(mac_en),
    .write_en(write_en),
    .write_row(write_row),
    .write_col(write_col),
    .done(done)
  );

  gcn_transform_scheduler #(
    .FEATURE_ROWS(1),
    .FEATURE_COLS(1),
    .WEIGHT_COLS(1)
  ) dut1 (
    .clk(clk),
    .reset(reset),
    .start(s_start),
    .abort(s_abort),
    .out_ready(s_ready),
    .busy(s_busy),
    .read_en(s_read),
    .feature_row(s_row),
    .k_index(s_k),
    .weight_col(s_col),
    .mac_clear(s_clear),
    .mac_en(s_mac),
    .write_en(s_write),
    .write_row(s_wrow),
    .write_col(s_wcol),
    .done(s_done)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;
  int done_at;
  int n_done;
  int wr_q[$];
  bit m_act = 1'b0;
  int m_pos = 0;
  bit m_mac = 1'b0;
  bit lw_en = 1'b0;
  int lw_v = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: m_pos counts productive cycles
  // since start; stalls freeze it.
  function automatic int off();
    return (m_pos - 1) % L;
  endfunction
  function automatic int m_row();
    return ((m_pos - 1) / L) / WC;
  endfunction
  function automatic int m_col();
    return ((m_pos - 1) / L) % WC;
  endfunction
  function automatic bit m_clear();
    return m_act && m_pos < N && off() == 0;
  endfunction
  function automatic bit m_read();
    return m_act && m_pos < N &&
           off() >= 1 && off() <= FC;
  endfunction
  function automatic bit m_write();
    return m_act && m_pos < N && off() == FC + 2;
  endfunction
  function automatic bit m_done();
    return m_act && m_pos == N;
  endfunction

  function automatic logic [13:0] outs();
    return {busy, read_en, feature_row, k_index,
            weight_col, mac_clear, mac_en, write_en,
            write_row, write_col, done};
  endfunction

  task automatic compare();
    chk("ctl",
        {busy, mac_clear, read_en, mac_en, write_en, done},
        {m_act, m_clear(), m_read(), m_mac,
         m_write(), m_done()});
    if (m_read()) begin
      chk("k", k_index, off() - 1);
      chk("row", feature_row, m_row());
      chk("col", weight_col, m_col());
    end
    if (m_write()) begin
      chk("wrow", write_row, m_row());
      chk("wcol", write_col, m_col());
    end
    lw_en = write_en;
    lw_v = write_row * 4 + write_col;
  endtask

  task automatic tick();
    bit rd;
    @(posedge clk);
    cyc++;
    if (reset && !abort && lw_en && out_ready)
      wr_q.push_back(lw_v);
    rd = m_read();
    if (!reset || abort) begin
      m_act = 1'b0;
      m_mac = 1'b0;
    end else begin
      m_mac = rd;
      if (!m_act) begin
        if (start) begin
          m_act = 1'b1;
          m_pos = 1;
          t0 = cyc;
        end
      end else if (!(m_write() && !out_ready)) begin
        if (m_pos == N) m_act = 1'b0;
        else m_pos++;
      end
    end
    #1;
    compare();
    if (done) begin
      n_done++;
      done_at = cyc - t0 + 1;
    end
  endtask

  // Cycle numbering: the start-sampling edge
  // ends cycle 0; inputs set after a check
  // belong to the current cycle cy.
  task automatic run_pass(input int stall,
                          input bit rnd,
                          input int restart_at,
                          input int abort_at,
                          input int reset_at);
    int budget;
    int stall_left;
    int cy;
    budget = 3000;
    stall_left = stall;
    n_done = 0;
    done_at = -1;
    wr_q.delete();
    start = 1'b1;
    abort = 1'b0;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    while (m_act && budget > 0) begin
      budget--;
      cy = cyc - t0 + 1;
      if (cy == reset_at) begin
        #2 reset = 1'b0;
        #1;
        chk("async_rst", outs(), 0);
        m_act = 1'b0;
        m_mac = 1'b0;
        lw_en = 1'b0;
        tick();
        tick();
        @(negedge clk);
        reset = 1'b1;
        break;
      end
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!rnd && m_write() && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end
      start = (cy == restart_at);
      abort = (cy == abort_at);
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    out_ready = 1'b1;
    chk("pass_end", budget > 0, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [5:0] sv [6];

  initial begin
    #12;
    chk("reset_outs", outs(), 0);
    chk("reset_small",
        {s_busy, s_read, s_clear, s_mac, s_write, s_done},
        0);
    @(negedge clk);
    reset = 1'b1;
    idle(3);

    run_pass(0, 1'b0, 0, 0, 0);
    chk("done_cyc", done_at, 43);
    chk("done_cnt", n_done, 1);
    chk("wr_cnt", wr_q.size(), E);
    for (int i = 0; i < E && i < wr_q.size(); i++)
      chk("wr_order", wr_q[i], (i / WC) * 4 + (i % WC));
    idle(2);

    run_pass(5, 1'b0, 0, 0, 0);
    chk("stall_done_cyc", done_at, 48);
    chk("stall_wr_cnt", wr_q.size(), E);
    idle(2);

    run_pass(0, 1'b0, 10, 0, 0);
    chk("restart_done_cyc", done_at, 43);
    chk("restart_done_cnt", n_done, 1);
    chk("restart_wr_cnt", wr_q.size(), E);
    idle(2);

    run_pass(0, 1'b0, 0, 4, 0);
    chk("abort_quiet", {busy, read_en, mac_en}, 0);
    idle(10);
    chk("abort_no_done", n_done, 0);

    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_vs_start", busy, 0);
    idle(2);

    run_pass(0, 1'b0, 0, 0, 0);
    chk("post_abort_done", done_at, 43);

    run_pass(0, 1'b0, 0, 0, 20);
    idle(6);
    chk("post_rst_idle", busy, 0);
    run_pass(0, 1'b0, 0, 0, 0);
    chk("post_rst_done", done_at, 43);
    chk("post_rst_wr", wr_q.size(), E);

    for (int p = 0; p < 6; p++) begin
      run_pass(0, 1'b1,
               int'($urandom_range(2, 60)),
               ($urandom_range(0, 2) == 0) ?
                 int'($urandom_range(2, 60)) : 0,
               0);
      idle(int'($urandom_range(1, 4)));
    end

    sv = '{6'b110000, 6'b101000, 6'b100100,
           6'b100010, 6'b100001, 6'b000000};
    @(negedge clk);
    s_start = 1'b1;
    @(posedge clk);
    #1;
    s_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("small_ctl",
          {s_busy, s_clear, s_read, s_mac, s_write, s_done},
          sv[i]);
      if (i == 3) chk("small_wr", {s_wrow, s_wcol}, 0);
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
